// File: rtl/ifid_pipe_ctrl_pkg.sv
// Shared pipeline definitions for the IF/ID/EX front end: NOP encoding,
// default reset PC, control-bundle width, register-ID width and the
// stall/flush FSM state encoding.
package ifid_pipe_ctrl_pkg;

   localparam int          CTRL_W_DEF    = 10;
   localparam int          REG_W         = 5;
   localparam int          MAX_STALL_DEF = 4;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } pipe_state_t;

   // Three-bit increment that sticks at 7 instead of wrapping.
   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/ifid_pipe_ctrl_stall_fsm.sv
// Stall/flush tracking FSM for ifid_pipe_ctrl.
// Holds the pipeline state, the saturating consecutive-stall counter and the
// sticky stall_timeout flag. With STALL_PERF_EN defined it also keeps
// free-running counts of cycles spent in STALL and FLUSH.
module ifid_stall_fsm
   import ifid_pipe_ctrl_pkg::*;
#(
   parameter int MAX_STALL = MAX_STALL_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hazard_mux,
   input  logic        flush,
   output logic [1:0]  state,
`ifdef STALL_PERF_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles,
`endif
   output logic        stall_timeout
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_STALL);

   pipe_state_t state_reg, state_next;
   logic [2:0]  stall_cnt_reg, stall_cnt_next;
   logic        timeout_reg, timeout_next;

   // Next state depends only on this cycle's controls: flush wins over stall,
   // and the count covers the cycle being entered so the flag lands on the
   // same edge as the MAX_STALL-th consecutive stall.
   always_comb begin
      state_next     = RUN;
      stall_cnt_next = 3'd0;
      timeout_next   = timeout_reg;
      if (flush) begin
         state_next = FLUSH;
      end else if (hazard_mux) begin
         state_next = STALL;
      end
      if (state_next == STALL) begin
         stall_cnt_next = sat_inc3(stall_cnt_reg);
      end
      if (stall_cnt_next >= MAX_CNT) begin
         timeout_next = 1'b1;
      end
   end

   // State, stall counter and sticky timeout registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         stall_cnt_reg <= 3'd0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         timeout_reg   <= timeout_next;
      end
   end

   assign state         = state_reg;
   assign stall_timeout = timeout_reg;

`ifdef STALL_PERF_EN
   logic [31:0] stall_cycles_reg, flush_cycles_reg;

   // Cycle counters for STALL/FLUSH occupancy, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_reg <= 32'd0;
         flush_cycles_reg <= 32'd0;
      end else begin
         if (state_next == STALL) stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (state_next == FLUSH) flush_cycles_reg <= flush_cycles_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_cycles = flush_cycles_reg;
`endif

endmodule

// File: rtl/ifid_pipe_ctrl.sv
// Front-end pipeline register control: PC, IF/ID register and the ID/EX
// control/register-ID slice. Applies load-use stalls and bubbles from the
// hazard unit and branch flushes from EX; feeds idex_rt/idex_memread back.
// Optional feature macro: STALL_PERF_EN (adds stall_cycles/flush_cycles).
module ifid_pipe_ctrl
   import ifid_pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          CTRL_W    = CTRL_W_DEF,
   parameter int          MAX_STALL = MAX_STALL_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              hazard_mux,
   input  logic              flush,
   input  logic [31:0]       flush_target,
   input  logic [31:0]       imem_rdata,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   output logic [31:0]       pc,
   output logic [31:0]       ifid_instr,
   output logic [31:0]       ifid_pc4,
   output logic              ifid_valid,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic [4:0]        idex_rs,
   output logic [4:0]        idex_rt,
   output logic [4:0]        idex_rd,
   output logic              idex_memread,
   output logic [1:0]        state,
`ifdef STALL_PERF_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles,
`endif
   output logic              proto_err,
   output logic              stall_timeout
);

   logic [31:0]       pc_reg;
   logic [31:0]       ifid_instr_reg, ifid_pc4_reg;
   logic              ifid_valid_reg;
   logic [CTRL_W-1:0] idex_ctrl_reg;
   logic [REG_W-1:0]  idex_rs_reg, idex_rt_reg, idex_rd_reg;
   logic              proto_err_reg;
   logic [31:0]       pc_plus4;
   logic              bubble;

   // Natural 32-bit wrap: FFFF_FFFC + 4 -> 0.
   assign pc_plus4 = pc_reg + 32'd4;
   // An empty IF/ID slot also bubbles so a flushed NOP never carries stale IDs.
   assign bubble   = hazard_mux | flush | ~ifid_valid_reg;

   // PC register: redirect on flush, otherwise advance only when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg <= RESET_PC;
      end else if (flush) begin
         pc_reg <= flush_target;
      end else if (pc_write) begin
         pc_reg <= pc_plus4;
      end
   end

   // IF/ID register: flush squashes to NOP, enable loads, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_instr_reg <= NOP_INSTR;
         ifid_pc4_reg   <= 32'd0;
         ifid_valid_reg <= 1'b0;
      end else if (flush) begin
         ifid_instr_reg <= NOP_INSTR;
         ifid_pc4_reg   <= 32'd0;
         ifid_valid_reg <= 1'b0;
      end else if (ifid_write) begin
         ifid_instr_reg <= imem_rdata;
         ifid_pc4_reg   <= pc_plus4;
         ifid_valid_reg <= 1'b1;
      end
   end

   // ID/EX slice: bubbles zero the IDs too so the hazard unit sees no false match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_ctrl_reg <= '0;
         idex_rs_reg   <= '0;
         idex_rt_reg   <= '0;
         idex_rd_reg   <= '0;
      end else if (bubble) begin
         idex_ctrl_reg <= '0;
         idex_rs_reg   <= '0;
         idex_rt_reg   <= '0;
         idex_rd_reg   <= '0;
      end else begin
         idex_ctrl_reg <= id_ctrl;
         idex_rs_reg   <= id_rs;
         idex_rt_reg   <= id_rt;
         idex_rd_reg   <= id_rd;
      end
   end

   // Sticky flag for mismatched PC/IF-ID enables outside a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proto_err_reg <= 1'b0;
      end else if ((pc_write != ifid_write) && !flush) begin
         proto_err_reg <= 1'b1;
      end
   end

   ifid_stall_fsm #(
      .MAX_STALL    (MAX_STALL)
   ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .hazard_mux   (hazard_mux),
      .flush        (flush),
      .state        (state),
`ifdef STALL_PERF_EN
      .stall_cycles (stall_cycles),
      .flush_cycles (flush_cycles),
`endif
      .stall_timeout(stall_timeout)
   );

   assign pc           = pc_reg;
   assign ifid_instr   = ifid_instr_reg;
   assign ifid_pc4     = ifid_pc4_reg;
   assign ifid_valid   = ifid_valid_reg;
   assign idex_ctrl    = idex_ctrl_reg;
   assign idex_rs      = idex_rs_reg;
   assign idex_rt      = idex_rt_reg;
   assign idex_rd      = idex_rd_reg;
   assign idex_memread = idex_ctrl_reg[0];
   assign proto_err    = proto_err_reg;

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Directed testbench for ifid_pipe_ctrl. Instruction memory returns
// {16'hA5A5, pc[15:0]} so the expected fetched word follows from the PC.
// Optional feature macro: STALL_PERF_EN.
module tb_ifid_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, ifid_write, hazard_mux, flush;
   logic [31:0] flush_target;
   logic [31:0] imem_rdata;
   logic [9:0]  id_ctrl;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] pc, ifid_instr, ifid_pc4;
   logic        ifid_valid;
   logic [9:0]  idex_ctrl;
   logic [4:0]  idex_rs, idex_rt, idex_rd;
   logic        idex_memread;
   logic [1:0]  state;
   logic        proto_err, stall_timeout;
`ifdef STALL_PERF_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign imem_rdata = {16'hA5A5, pc[15:0]};

   ifid_pipe_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .hazard_mux   (hazard_mux),
      .flush        (flush),
      .flush_target (flush_target),
      .imem_rdata   (imem_rdata),
      .id_ctrl      (id_ctrl),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .pc           (pc),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
      .idex_ctrl    (idex_ctrl),
      .idex_rs      (idex_rs),
      .idex_rt      (idex_rt),
      .idex_rd      (idex_rd),
      .idex_memread (idex_memread),
      .state        (state),
`ifdef STALL_PERF_EN
      .stall_cycles (stall_cycles),
      .flush_cycles (flush_cycles),
`endif
      .proto_err    (proto_err),
      .stall_timeout(stall_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %08h", tag, got);
      end
   endtask

   // Apply one cycle of controls at the falling edge, clock it, sample on the next falling edge.
   task automatic step(input logic pw, input logic iw, input logic hm, input logic fl,
                       input logic [31:0] tgt);
      pc_write     = pw;
      ifid_write   = iw;
      hazard_mux   = hm;
      flush        = fl;
      flush_target = tgt;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      pc_write = 1'b0; ifid_write = 1'b0; hazard_mux = 1'b0; flush = 1'b0;
      flush_target = 32'h0;
      id_ctrl = 10'h2A5; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
      repeat (2) @(negedge clk);

      check("rst_pc",        pc,            32'h0);
      check("rst_valid",     ifid_valid,    32'h0);
      check("rst_idex_ctrl", idex_ctrl,     32'h0);
      check("rst_state",     state,         32'h0);
      check("rst_proto",     proto_err,     32'h0);
      check("rst_timeout",   stall_timeout, 32'h0);
      rst_n = 1'b1;

      // Straight-line fetch.
      step(1, 1, 0, 0, 32'h0);
      check("run1_pc",    pc,         32'h4);
      check("run1_instr", ifid_instr, 32'hA5A5_0000);
      check("run1_pc4",   ifid_pc4,   32'h4);
      check("run1_valid", ifid_valid, 32'h1);
      check("run1_idex",  idex_ctrl,  32'h0);
      step(1, 1, 0, 0, 32'h0);
      check("run2_pc",    pc,           32'h8);
      check("run2_idex",  idex_ctrl,    32'h2A5);
      check("run2_rt",    idex_rt,      32'h2);
      check("run2_mrd",   idex_memread, 32'h1);
      step(1, 1, 0, 0, 32'h0);
      check("run3_pc",    pc,         32'hC);
      check("run3_instr", ifid_instr, 32'hA5A5_0008);

      // Load-use stall for one cycle.
      step(0, 0, 1, 0, 32'h0);
      check("lu_pc",    pc,           32'hC);
      check("lu_instr", ifid_instr,   32'hA5A5_0008);
      check("lu_idex",  idex_ctrl,    32'h0);
      check("lu_rt",    idex_rt,      32'h0);
      check("lu_mrd",   idex_memread, 32'h0);
      check("lu_state", state,        32'h1);
      step(1, 1, 0, 0, 32'h0);
      check("rel_pc",      pc,            32'h10);
      check("rel_state",   state,         32'h0);
      check("rel_idex",    idex_ctrl,     32'h2A5);
      check("rel_instr",   ifid_instr,    32'hA5A5_000C);
      check("rel_timeout", stall_timeout, 32'h0);

      // Flush wins over a simultaneous hazard.
      step(1, 1, 1, 1, 32'h100);
      check("fl_pc",    pc,         32'h100);
      check("fl_valid", ifid_valid, 32'h0);
      check("fl_instr", ifid_instr, 32'h0);
      check("fl_pc4",   ifid_pc4,   32'h0);
      check("fl_idex",  idex_ctrl,  32'h0);
      check("fl_state", state,      32'h2);
      step(1, 1, 0, 0, 32'h0);
      check("pf_pc",    pc,         32'h104);
      check("pf_state", state,      32'h0);
      check("pf_valid", ifid_valid, 32'h1);
      check("pf_idex",  idex_ctrl,  32'h0);
      check("pf_instr", ifid_instr, 32'hA5A5_0100);
      step(1, 1, 0, 0, 32'h0);
      check("pf2_pc",   pc,         32'h108);
      check("pf2_idex", idex_ctrl,  32'h2A5);

      // Four consecutive stalls trip the timeout on the fourth edge.
      step(0, 0, 1, 0, 32'h0);
      step(0, 0, 1, 0, 32'h0);
      step(0, 0, 1, 0, 32'h0);
      check("to3_timeout", stall_timeout, 32'h0);
      check("to3_pc",      pc,            32'h108);
      step(0, 0, 1, 0, 32'h0);
      check("to4_timeout", stall_timeout, 32'h1);
      check("to4_state",   state,         32'h1);
      step(1, 1, 0, 0, 32'h0);
      check("torel_timeout", stall_timeout, 32'h1);
      check("torel_state",   state,         32'h0);
      check("torel_pc",      pc,            32'h10C);

      // Mismatched enables: PC moves, IF/ID holds, flag sticks.
      step(1, 0, 0, 0, 32'h0);
      check("pe_pc",    pc,         32'h110);
      check("pe_instr", ifid_instr, 32'hA5A5_0108);
      check("pe_pc4",   ifid_pc4,   32'h10C);
      check("pe_flag",  proto_err,  32'h1);
      step(1, 1, 0, 0, 32'h0);
      check("pe_sticky", proto_err,  32'h1);
      check("pe2_instr", ifid_instr, 32'hA5A5_0110);

      // PC wrap at the top of the address space.
      step(1, 1, 0, 1, 32'hFFFF_FFFC);
      check("wr_pc", pc, 32'hFFFF_FFFC);
      step(1, 1, 0, 0, 32'h0);
      check("wr_pc0",   pc,         32'h0);
      check("wr_pc4",   ifid_pc4,   32'h0);
      check("wr_instr", ifid_instr, 32'hA5A5_FFFC);
      check("wr_valid", ifid_valid, 32'h1);

      // Asynchronous reset in the middle of a stall, between clock edges.
      step(0, 0, 1, 0, 32'h0);
      check("ar_pre_state", state, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_pc",      pc,            32'h0);
      check("ar_state",   state,         32'h0);
      check("ar_valid",   ifid_valid,    32'h0);
      check("ar_instr",   ifid_instr,    32'h0);
      check("ar_idex",    idex_ctrl,     32'h0);
      check("ar_proto",   proto_err,     32'h0);
      check("ar_timeout", stall_timeout, 32'h0);
      hazard_mux = 1'b0; pc_write = 1'b0; ifid_write = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);

`ifdef STALL_PERF_EN
      check("perf_rst_stall", stall_cycles, 32'd0);
      step(0, 0, 1, 0, 32'h0);
      step(0, 0, 1, 0, 32'h0);
      step(1, 1, 0, 1, 32'h40);
      check("perf_stall", stall_cycles, 32'd2);
      check("perf_flush", flush_cycles, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
